// File: rtl/uart_rx_fc.sv
// Parametrised UART receiver: synchronised, majority-voted bit sampling feeding a
// held valid/ready output word with per-word error flags, overrun and break pulses.
module uart_rx_fc #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_baud_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_data_valid,
   input  logic                 i_data_ready,
   output logic                 o_parity_error,
   output logic                 o_frame_error,
   output logic                 o_overrun,
   output logic                 o_break,
   output logic                 o_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] CNT_EVAL = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [1:0]             samp_q, samp_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;
   logic                   seen_one_q, seen_one_d;
   logic                   done_q, done_d;
   logic                   brk_d;
   logic                   maj;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   // NOTE: the synchroniser resets to the idle level so reset release never fakes a start bit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) sync_q <= '1;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
   end

   assign rx_s   = sync_q[SYNC_STAGES-1];
   assign o_busy = (state_q != IDLE);

   // NOTE: every variable gets its default first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      seen_one_d = seen_one_q;
      done_d     = 1'b0;
      brk_d      = 1'b0;
      maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

      if (i_baud_tick) begin
         if (state_q != IDLE && state_q != BREAK_WAIT) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) samp_d[0] = rx_s;
            if (cnt_q == CNT_S1) samp_d[1] = rx_s;
         end

         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d    = START;
                  cnt_d      = CW'(1);
                  bit_cnt_d  = '0;
                  par_err_d  = 1'b0;
                  frm_err_d  = 1'b0;
                  seen_one_d = 1'b0;
               end
            end
            START: begin
               if (cnt_q == CNT_EVAL && maj) state_d = IDLE;
               else if (cnt_q == CNT_LAST)   state_d = DATA;
            end
            DATA: begin
               if (cnt_q == CNT_EVAL) begin
                  shift_d = {maj, shift_q[DATA_BITS-1:1]};
                  if (maj) seen_one_d = 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (cnt_q == CNT_EVAL) begin
                  par_err_d = maj ^ (^shift_q) ^ (PARITY_ODD != 0);
                  if (maj) seen_one_d = 1'b1;
               end
               if (cnt_q == CNT_LAST) state_d = STOP;
            end
            STOP: begin
               if (cnt_q == CNT_EVAL) begin
                  if (!maj) frm_err_d = 1'b1;
                  // The last stop bit ends half a bit early so a following start edge is caught on time.
                  if (bit_cnt_q == STOP_LAST) begin
                     if (!seen_one_q && !maj) begin
                        state_d = BREAK_WAIT;
                        brk_d   = 1'b1;
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else if (maj) begin
                     seen_one_d = 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            BREAK_WAIT: begin
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         samp_q     <= '0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         seen_one_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         seen_one_q <= seen_one_d;
         done_q     <= done_d;
      end
   end

   // Output word: a completed frame loads only into an empty or simultaneously drained slot.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_data         <= '0;
         o_data_valid   <= 1'b0;
         o_parity_error <= 1'b0;
         o_frame_error  <= 1'b0;
         o_overrun      <= 1'b0;
         o_break        <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         o_break   <= brk_d;
         if (o_data_valid && i_data_ready) begin
            o_data_valid   <= 1'b0;
            o_parity_error <= 1'b0;
            o_frame_error  <= 1'b0;
         end
         if (done_q) begin
            if (!o_data_valid || i_data_ready) begin
               o_data         <= shift_q;
               o_data_valid   <= 1'b1;
               o_parity_error <= par_err_q;
               o_frame_error  <= frm_err_q;
            end else begin
               o_overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fc.sv
// Self-checking bench for uart_rx_fc: three configurations (8N1/16x, 7E1/8x, 8N2/12x)
// driven with directed and random frames against a frame-level reference model.
module tb_uart_rx_fc;

   localparam int TDIV = 4;
   localparam int OS_A = 16;
   localparam int OS_B = 8;
   localparam int OS_C = 12;
   localparam int SYNC = 2;

   typedef struct packed {
      logic       fe;
      logic       pe;
      logic [8:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        baud_tick;
   int unsigned tick_cnt = 0;
   int unsigned cyc = 0;
   logic [2:0]  rx_line;
   logic [2:0]  ready;
   logic [7:0]  data_a;
   logic [6:0]  data_b;
   logic [7:0]  data_c;
   logic [2:0]  valid, perr, ferr, ovr, brk, busy;

   int n_tests = 0;
   int n_fail  = 0;

   word_t       got0[$];
   word_t       got1[$];
   word_t       got2[$];
   int unsigned ovr_cnt[3];
   int unsigned brk_cnt[3];
   int unsigned vcyc_a = 0;
   int unsigned rise_cyc_a = 0;
   logic        prev_valid_a = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      tick_cnt <= (tick_cnt == TDIV - 1) ? 0 : tick_cnt + 1;
   end
   assign baud_tick = (tick_cnt == 0);

   uart_rx_fc #(.DATA_BITS(8), .OVERSAMPLE(OS_A), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(baud_tick), .i_rx(rx_line[0]),
      .o_data(data_a), .o_data_valid(valid[0]), .i_data_ready(ready[0]),
      .o_parity_error(perr[0]), .o_frame_error(ferr[0]), .o_overrun(ovr[0]),
      .o_break(brk[0]), .o_busy(busy[0]));

   uart_rx_fc #(.DATA_BITS(7), .OVERSAMPLE(OS_B), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(baud_tick), .i_rx(rx_line[1]),
      .o_data(data_b), .o_data_valid(valid[1]), .i_data_ready(ready[1]),
      .o_parity_error(perr[1]), .o_frame_error(ferr[1]), .o_overrun(ovr[1]),
      .o_break(brk[1]), .o_busy(busy[1]));

   uart_rx_fc #(.DATA_BITS(8), .OVERSAMPLE(OS_C), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(2), .SYNC_STAGES(SYNC)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(baud_tick), .i_rx(rx_line[2]),
      .o_data(data_c), .o_data_valid(valid[2]), .i_data_ready(ready[2]),
      .o_parity_error(perr[2]), .o_frame_error(ferr[2]), .o_overrun(ovr[2]),
      .o_break(brk[2]), .o_busy(busy[2]));

   // Accepted words, pulse counts and the latest valid rise, all observed mid-cycle.
   always @(negedge clk) begin
      if (valid[0] && ready[0]) got0.push_back({ferr[0], perr[0], 1'b0, data_a});
      if (valid[1] && ready[1]) got1.push_back({ferr[1], perr[1], 2'b00, data_b});
      if (valid[2] && ready[2]) got2.push_back({ferr[2], perr[2], 1'b0, data_c});
      for (int i = 0; i < 3; i++) begin
         if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
         if (brk[i] === 1'b1) brk_cnt[i] <= brk_cnt[i] + 1;
      end
      if (valid[0] === 1'b1) vcyc_a <= vcyc_a + 1;
      if (valid[0] === 1'b1 && !prev_valid_a) rise_cyc_a <= cyc;
      prev_valid_a <= valid[0];
   end

   function automatic word_t model(input logic [8:0] d, input int nbits, input bit par_en,
                                   input bit par_odd, input logic par_bit, input int nstop,
                                   input logic [1:0] stops);
      word_t       w;
      logic [8:0]  mask;
      int          ones;
      mask   = 9'((1 << nbits) - 1);
      ones   = $countones(d & mask);
      w.data = d & mask;
      w.pe   = par_en && (par_bit != 1'((ones + int'(par_odd)) % 2));
      w.fe   = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
      return w;
   endfunction

   // First clock edge at or after 'from' that carries a baud tick.
   function automatic int unsigned tick_edge(input int unsigned from);
      int unsigned t;
      t = from;
      while (((t - 1) % TDIV) != 0) t++;
      return t;
   endfunction

   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic idle_bits(input int lane, input int os, input int nbits);
      rx_line[lane] = 1'b1;
      repeat (nbits * os * TDIV) @(negedge clk);
   endtask

   task automatic drive_bit(input int lane, input logic v, input int os);
      rx_line[lane] = v;
      repeat (os * TDIV) @(negedge clk);
   endtask

   task automatic send_frame(input int lane, input int os, input int nbits, input logic [8:0] d,
                             input bit par_en, input logic par_bit, input int nstop,
                             input logic [1:0] stops);
      drive_bit(lane, 1'b0, os);
      for (int i = 0; i < nbits; i++) drive_bit(lane, d[i], os);
      if (par_en) drive_bit(lane, par_bit, os);
      for (int i = 0; i < nstop; i++) drive_bit(lane, stops[i], os);
      rx_line[lane] = 1'b1;
   endtask

   task automatic pop_got(input int lane, output word_t w, output bit ok);
      ok = 1'b0;
      w  = '0;
      case (lane)
         0: if (got0.size() > 0) begin w = got0.pop_front(); ok = 1'b1; end
         1: if (got1.size() > 0) begin w = got1.pop_front(); ok = 1'b1; end
         default: if (got2.size() > 0) begin w = got2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rx_line = '1;
      ready   = '1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({valid, perr, ferr} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_flags: valid/pe/fe got %b want 0", {valid, perr, ferr});
      end
      n_tests++;
      if ({ovr, brk, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_pulses: ovr/brk/busy got %b want 0", {ovr, brk, busy});
      end
      n_tests++;
      if ({data_a, data_b, data_c} !== 23'b0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h/%h want 0", data_a, data_b, data_c);
      end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if (busy !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b want 000", busy);
      end
   endtask

   task automatic test_basic_a5();
      int unsigned fall, trig, evt, v0;
      word_t       w, exp;
      bit          ok;
      exp  = model(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11);
      v0   = vcyc_a;
      fall = cyc;
      send_frame(0, OS_A, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);
      idle_bits(0, OS_A, 2);
      trig = tick_edge(fall + SYNC + 1);
      evt  = trig + (9 * OS_A + OS_A / 2 + 1) * TDIV;
      pop_got(0, w, ok);
      n_tests++;
      if (!ok || w !== exp) begin
         n_fail++;
         $display("FAIL basic_word: got %h (present=%0d) want %h", w, ok, exp);
      end
      n_tests++;
      if (vcyc_a - v0 !== 1) begin
         n_fail++;
         $display("FAIL basic_valid_len: got %0d cycles want 1", vcyc_a - v0);
      end
      n_tests++;
      if (!(rise_cyc_a > evt && rise_cyc_a <= evt + 2)) begin
         n_fail++;
         $display("FAIL basic_latency: valid rose at edge %0d want %0d..%0d", rise_cyc_a, evt + 1, evt + 2);
      end
   endtask

   task automatic test_parity();
      word_t w;
      bit    ok;
      send_frame(1, OS_B, 7, 9'h003, 1'b1, 1'b1, 1, 2'b11);
      idle_bits(1, OS_B, 2);
      pop_got(1, w, ok);
      n_tests++;
      if (!ok || w !== model(9'h003, 7, 1'b1, 1'b0, 1'b1, 1, 2'b11)) begin
         n_fail++;
         $display("FAIL parity_bad: got %h (present=%0d) want %h", w, ok,
                  model(9'h003, 7, 1'b1, 1'b0, 1'b1, 1, 2'b11));
      end
      send_frame(1, OS_B, 7, 9'h003, 1'b1, 1'b0, 1, 2'b11);
      idle_bits(1, OS_B, 2);
      pop_got(1, w, ok);
      n_tests++;
      if (!ok || w !== model(9'h003, 7, 1'b1, 1'b0, 1'b0, 1, 2'b11)) begin
         n_fail++;
         $display("FAIL parity_good: got %h (present=%0d) want %h", w, ok,
                  model(9'h003, 7, 1'b1, 1'b0, 1'b0, 1, 2'b11));
      end
   endtask

   task automatic test_false_start();
      int unsigned fall, trig, b0;
      b0   = brk_cnt[2];
      fall = cyc;
      rx_line[2] = 1'b0;
      repeat (3 * TDIV) @(negedge clk);
      rx_line[2] = 1'b1;
      trig = tick_edge(fall + SYNC + 1);
      wait_cyc(trig + (OS_C / 2) * TDIV);
      n_tests++;
      if (busy[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL false_start_busy_hold: got %b want 1", busy[2]);
      end
      wait_cyc(trig + (OS_C / 2 + 1) * TDIV);
      n_tests++;
      if (busy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start_busy_fall: got %b want 0", busy[2]);
      end
      idle_bits(2, OS_C, 2);
      n_tests++;
      if (got2.size() != 0 || {valid[2], perr[2], ferr[2]} !== 3'b000 || brk_cnt[2] != b0) begin
         n_fail++;
         $display("FAIL false_start_quiet: words %0d flags %b breaks %0d want 0",
                  got2.size(), {valid[2], perr[2], ferr[2]}, brk_cnt[2] - b0);
      end
   endtask

   task automatic test_overrun();
      int unsigned o0;
      word_t       w;
      bit          ok;
      ready[0] = 1'b0;
      o0 = ovr_cnt[0];
      send_frame(0, OS_A, 8, 9'h011, 1'b0, 1'b0, 1, 2'b11);
      send_frame(0, OS_A, 8, 9'h022, 1'b0, 1'b0, 1, 2'b11);
      idle_bits(0, OS_A, 2);
      n_tests++;
      if ({valid[0], perr[0], ferr[0], data_a} !== {3'b100, 8'h11}) begin
         n_fail++;
         $display("FAIL overrun_hold: got v/pe/fe %b data %h want 100 data 11",
                  {valid[0], perr[0], ferr[0]}, data_a);
      end
      n_tests++;
      if (ovr_cnt[0] - o0 !== 1) begin
         n_fail++;
         $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt[0] - o0);
      end
      #1 ready[0] = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (valid[0] !== 1'b0 || data_a !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_drain: got valid %b data %h want 0 data 11", valid[0], data_a);
      end
      got0.delete();
      send_frame(0, OS_A, 8, 9'h033, 1'b0, 1'b0, 1, 2'b11);
      idle_bits(0, OS_A, 2);
      pop_got(0, w, ok);
      n_tests++;
      if (!ok || w !== model(9'h033, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11)) begin
         n_fail++;
         $display("FAIL overrun_next: got %h (present=%0d) want 033", w, ok);
      end
   endtask

   task automatic test_break();
      int unsigned b0, o0;
      word_t       w;
      bit          ok;
      b0 = brk_cnt[0];
      o0 = ovr_cnt[0];
      got0.delete();
      rx_line[0] = 1'b0;
      repeat (12 * OS_A * TDIV) @(negedge clk);
      n_tests++;
      if (brk_cnt[0] - b0 !== 1 || got0.size() != 0) begin
         n_fail++;
         $display("FAIL break_pulse: got %0d pulses %0d words want 1 pulse 0 words",
                  brk_cnt[0] - b0, got0.size());
      end
      n_tests++;
      if (busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL break_busy_low_line: got %b want 1", busy[0]);
      end
      idle_bits(0, OS_A, 2);
      n_tests++;
      if (busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL break_busy_released: got %b want 0", busy[0]);
      end
      send_frame(0, OS_A, 8, 9'h05A, 1'b0, 1'b0, 1, 2'b11);
      idle_bits(0, OS_A, 2);
      pop_got(0, w, ok);
      n_tests++;
      if (!ok || w !== model(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11) || ovr_cnt[0] != o0) begin
         n_fail++;
         $display("FAIL break_recover: got %h (present=%0d) overruns %0d want 05A",
                  w, ok, ovr_cnt[0] - o0);
      end
   endtask

   task automatic test_random(input int lane, input int os, input int nbits, input bit par_en,
                              input int nframes);
      word_t       exp_q[$];
      word_t       w;
      bit          ok;
      logic [8:0]  d;
      logic        par_bit;
      logic        stop_ok;
      int unsigned o0;
      o0 = ovr_cnt[lane];
      for (int f = 0; f < nframes; f++) begin
         d       = 9'($urandom_range(0, (1 << nbits) - 1));
         par_bit = 1'($urandom_range(0, 1));
         stop_ok = ($urandom_range(0, 4) != 0);
         if (d == 9'h0 && (!par_en || !par_bit) && !stop_ok) stop_ok = 1'b1;
         exp_q.push_back(model(d, nbits, par_en, 1'b0, par_bit, 1, {1'b1, stop_ok}));
         send_frame(lane, os, nbits, d, par_en, par_bit, 1, {1'b1, stop_ok});
         idle_bits(lane, os, stop_ok ? int'($urandom_range(0, 1)) : 1);
      end
      idle_bits(lane, os, 2);
      foreach (exp_q[i]) begin
         pop_got(lane, w, ok);
         n_tests++;
         if (!ok || w !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_lane%0d_frame%0d: got %h (present=%0d) want %h",
                     lane, i, w, ok, exp_q[i]);
         end
      end
      n_tests++;
      if (ovr_cnt[lane] != o0) begin
         n_fail++;
         $display("FAIL random_lane%0d_overrun: got %0d pulses want 0", lane, ovr_cnt[lane] - o0);
      end
   endtask

   task automatic test_stop2_reset();
      word_t       w;
      bit          ok;
      int unsigned o0, b0;
      got2.delete();
      send_frame(2, OS_C, 8, 9'h07E, 1'b0, 1'b0, 2, 2'b01);
      idle_bits(2, OS_C, 2);
      pop_got(2, w, ok);
      n_tests++;
      if (!ok || w !== model(9'h07E, 8, 1'b0, 1'b0, 1'b0, 2, 2'b01)) begin
         n_fail++;
         $display("FAIL stop2_frame_error: got %h (present=%0d) want %h", w, ok,
                  model(9'h07E, 8, 1'b0, 1'b0, 1'b0, 2, 2'b01));
      end
      drive_bit(2, 1'b0, OS_C);
      drive_bit(2, 1'b0, OS_C);
      drive_bit(2, 1'b1, OS_C);
      drive_bit(2, 1'b0, OS_C);
      rst_n      = 1'b0;
      rx_line[2] = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({valid[2], perr[2], ferr[2], ovr[2], brk[2], busy[2], data_c} !== 14'b0) begin
         n_fail++;
         $display("FAIL midframe_reset: got flags %b data %h want 0",
                  {valid[2], perr[2], ferr[2], ovr[2], brk[2], busy[2]}, data_c);
      end
      o0 = ovr_cnt[2];
      b0 = brk_cnt[2];
      idle_bits(2, OS_C, 12);
      n_tests++;
      if (got2.size() != 0 || busy[2] !== 1'b0 || ovr_cnt[2] != o0 || brk_cnt[2] != b0) begin
         n_fail++;
         $display("FAIL midframe_reset_quiet: words %0d busy %b ovr %0d brk %0d want 0",
                  got2.size(), busy[2], ovr_cnt[2] - o0, brk_cnt[2] - b0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_line = '1;
      ready   = '1;
      for (int i = 0; i < 3; i++) begin
         ovr_cnt[i] = 0;
         brk_cnt[i] = 0;
      end
      @(negedge clk);
      test_reset();
      test_basic_a5();
      test_parity();
      test_false_start();
      test_overrun();
      test_break();
      test_random(0, OS_A, 8, 1'b0, 16);
      test_random(1, OS_B, 7, 1'b1, 20);
      test_stop2_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
